// File: rtl/nibble_bank_pkg.sv
// Shared geometry and FSM state type for the nibble bank writer.
package nibble_bank_pkg;
    localparam int NIB_W   = 4;
    localparam int NUM_NIB = 256;
    localparam int SEL_W   = 8;
    localparam int BANK_W  = NIB_W * NUM_NIB;
    localparam int CNT_W   = SEL_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/nibble_bank_writer_if.sv
// Write-side handshake bundle: command/data offer with wr_valid, acceptance with wr_ready.
interface nibble_bank_writer_if;
    import nibble_bank_pkg::*;

    logic             wr_valid;
    logic             wr_ready;
    logic             wr_burst;
    logic [SEL_W-1:0] wr_sel;
    logic [SEL_W-1:0] burst_len;
    logic [NIB_W-1:0] wr_data;

    modport master (output wr_valid, wr_burst, wr_sel, burst_len, wr_data, input wr_ready);
    modport slave  (input wr_valid, wr_burst, wr_sel, burst_len, wr_data, output wr_ready);
endinterface

// File: rtl/nibble_wr_decode.sv
// Combinational index-to-one-hot nibble enable; all-zero when en_i is low.
module nibble_wr_decode
    import nibble_bank_pkg::*;
(
    input  logic               en_i,
    input  logic [SEL_W-1:0]   idx_i,
    output logic [NUM_NIB-1:0] onehot_o
);
    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end
    end
endmodule

// File: rtl/nibble_bank_writer.sv
// 256x4 register bank with single and burst writes; writes land one cycle after acceptance,
// wr_ready drops only in the one-cycle DONE state. NIBBLE_READBACK_EN adds a registered read port.
module nibble_bank_writer
    import nibble_bank_pkg::*;
#(
    parameter logic [NIB_W-1:0] FILL_VAL = 4'h0
) (
    input  logic              clk,
    input  logic              reset,
    nibble_bank_writer_if.slave wr,
    output logic [BANK_W-1:0] out,
    output logic              busy,
    output logic              done
`ifdef NIBBLE_READBACK_EN
    ,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [NIB_W-1:0]  rd_data
`endif
);
    state_t               state_q, state_d;
    logic [SEL_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     rem_q, rem_d;
    logic [BANK_W-1:0]    bank_q;
    logic                 wr_en;
    logic [SEL_W-1:0]     wr_idx;
    logic [NUM_NIB-1:0]   nib_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        wr_en   = 1'b0;
        wr_idx  = wr.wr_sel;
        case (state_q)
            ST_IDLE: begin
                if (wr.wr_valid) begin
                    if (wr.wr_burst) begin
                        // A zero length encodes a full-bank burst.
                        ptr_d   = wr.wr_sel;
                        rem_d   = (wr.burst_len == '0) ? CNT_W'(NUM_NIB) : {1'b0, wr.burst_len};
                        state_d = ST_BURST;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
            end
            ST_BURST: begin
                if (wr.wr_valid) begin
                    wr_en  = 1'b1;
                    wr_idx = ptr_q;
                    ptr_d  = ptr_q + 8'd1;
                    rem_d  = rem_q - 9'd1;
                    if (rem_q == 9'd1) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    nibble_wr_decode u_decode (
        .en_i     (wr_en),
        .idx_i    (wr_idx),
        .onehot_o (nib_en)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_q <= {NUM_NIB{FILL_VAL}};
        end else begin
            for (int k = 0; k < NUM_NIB; k++) begin
                if (nib_en[k]) begin
                    bank_q[k*NIB_W +: NIB_W] <= wr.wr_data;
                end
            end
        end
    end

    assign out         = bank_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign wr.wr_ready = (state_q != ST_DONE);

`ifdef NIBBLE_READBACK_EN
    logic [NIB_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= FILL_VAL;
        end else begin
            rd_data_q <= bank_q[rd_sel*NIB_W +: NIB_W];
        end
    end

    assign rd_data = rd_data_q;
`endif
endmodule

// File: tb/tb_nibble_bank_writer.sv
// Directed and randomized checks of nibble_bank_writer against an array model of the bank.
module tb_nibble_bank_writer;
    localparam logic [3:0] FILL = 4'h6;

    logic          clk = 1'b0;
    logic          reset;
    logic [1023:0] out_w;
    logic          busy_w, done_w;
`ifdef NIBBLE_READBACK_EN
    logic [7:0]    rd_sel;
    logic [3:0]    rd_data;
`endif

    nibble_bank_writer_if wif ();

    nibble_bank_writer #(.FILL_VAL(FILL)) dut (
        .clk   (clk),
        .reset (reset),
        .wr    (wif),
        .out   (out_w),
        .busy  (busy_w),
        .done  (done_w)
`ifdef NIBBLE_READBACK_EN
        ,
        .rd_sel  (rd_sel),
        .rd_data (rd_data)
`endif
    );

    always #5 clk = ~clk;

    logic [3:0] m [256];
    int n_tests = 0;
    int n_fail  = 0;
    int done_seen = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (done_w === 1'b1) done_seen++;
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic chk_bank(input string tag);
        logic [1023:0] e;
        int first = 0;
        bit found = 0;
        for (int k = 0; k < 256; k++) begin
            e[k*4 +: 4] = m[k];
            if (!found && out_w[k*4 +: 4] !== m[k]) begin
                first = k;
                found = 1;
            end
        end
        n_tests++;
        assert (out_w === e) else begin
            n_fail++;
            $error("FAIL %s: nibble %0d got %h expected %h", tag, first, out_w[first*4 +: 4], m[first]);
        end
    endtask

    task automatic drive(input logic v, input logic b, input logic [7:0] s,
                         input logic [7:0] l, input logic [3:0] d);
        wif.wr_valid  = v;
        wif.wr_burst  = b;
        wif.wr_sel    = s;
        wif.burst_len = l;
        wif.wr_data   = d;
    endtask

    task automatic model_fill();
        for (int k = 0; k < 256; k++) m[k] = FILL;
    endtask

    task automatic single_write(input logic [7:0] s, input logic [3:0] d, input string tag);
        drive(1'b1, 1'b0, s, 8'($urandom), d);
        m[s] = d;
        tick();
        chk({tag, "_busy"}, 32'(busy_w), 32'd0);
        chk_bank(tag);
    endtask

    // Offers a burst; data_is_idx writes the low nibble of each target index instead of random data.
    task automatic do_burst(input logic [7:0] start, input logic [7:0] len, input int stall_pct,
                            input int force_stall_i, input bit data_is_idx, input string tag);
        int n;
        logic [7:0] idx;
        logic [3:0] d;
        n = (len == 8'd0) ? 256 : int'(len);
        done_seen = 0;
        drive(1'b1, 1'b1, start, len, 4'($urandom));
        tick();
        chk({tag, "_cmd_busy"}, 32'(busy_w), 32'd1);
        chk({tag, "_cmd_rdy"}, 32'(wif.wr_ready), 32'd1);
        chk_bank({tag, "_cmd_nowrite"});
        for (int i = 0; i < n; i++) begin
            while (i == force_stall_i || int'($urandom_range(0, 99)) < stall_pct) begin
                drive(1'b0, 1'($urandom), 8'($urandom), 8'($urandom), 4'($urandom));
                tick();
                chk({tag, "_stall_busy"}, 32'(busy_w), 32'd1);
                chk_bank({tag, "_stall"});
                if (i == force_stall_i) force_stall_i = -1;
            end
            idx = 8'((int'(start) + i) % 256);
            d = data_is_idx ? idx[3:0] : 4'($urandom);
            drive(1'b1, 1'($urandom), 8'($urandom), 8'($urandom), d);
            m[idx] = d;
            tick();
            if (i < n - 1) begin
                if (done_w !== 1'b0 || busy_w !== 1'b1) begin
                    chk({tag, "_mid_done"}, 32'(done_w), 32'd0);
                    chk({tag, "_mid_busy"}, 32'(busy_w), 32'd1);
                end
            end else begin
                chk({tag, "_done"}, 32'(done_w), 32'd1);
                chk({tag, "_done_busy"}, 32'(busy_w), 32'd1);
                chk({tag, "_done_rdy"}, 32'(wif.wr_ready), 32'd0);
            end
        end
        chk_bank({tag, "_bank"});
        // Offer during DONE must not be accepted.
        drive(1'b1, 1'b0, 8'($urandom), 8'($urandom), 4'($urandom));
        tick();
        drive(1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
        chk({tag, "_after_done"}, 32'(done_w), 32'd0);
        chk({tag, "_after_busy"}, 32'(busy_w), 32'd0);
        chk({tag, "_after_rdy"}, 32'(wif.wr_ready), 32'd1);
        chk({tag, "_pulses"}, 32'(done_seen), 32'd1);
        chk_bank({tag, "_done_ignored"});
    endtask

    initial begin
        logic [7:0] s;
        logic [3:0] d;
        reset = 1'b1;
        drive(1'b1, 1'b0, 8'd9, 8'd0, 4'hF);
`ifdef NIBBLE_READBACK_EN
        rd_sel = 8'd0;
`endif
        model_fill();
        tick();
        tick();
        chk_bank("reset_bank");
        chk("reset_busy", 32'(busy_w), 32'd0);
        chk("reset_done", 32'(done_w), 32'd0);
        chk("reset_rdy", 32'(wif.wr_ready), 32'd1);
`ifdef NIBBLE_READBACK_EN
        chk("reset_rd_data", 32'(rd_data), 32'(FILL));
`endif
        reset = 1'b0;
        drive(1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
        tick();
        chk_bank("idle_bank");
        chk("idle_rdy", 32'(wif.wr_ready), 32'd1);

        single_write(8'd0, 4'hA, "sw0");
        single_write(8'd255, 4'h5, "sw255");
        chk("sw_lo", 32'(out_w[3:0]), 32'hA);
        chk("sw_hi", 32'(out_w[1023:1020]), 32'h5);

        for (int i = 0; i < 24; i++) begin
            s = 8'($urandom);
            d = 4'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                drive(1'b0, 1'($urandom), s, 8'($urandom), d);
                tick();
                chk("idle_novalid_busy", 32'(busy_w), 32'd0);
                chk_bank("idle_novalid");
            end else begin
                single_write(s, d, "rand_sw");
            end
        end

        do_burst(8'd254, 8'd3, 0, 1, 1'b0, "wrap");
        for (int i = 0; i < 4; i++) begin
            do_burst(8'($urandom), 8'($urandom_range(1, 20)), 30, -1, 1'b0, "rand_burst");
        end
        do_burst(8'd16, 8'd0, 10, -1, 1'b1, "full");
        for (int k = 0; k < 256; k++) begin
            if (out_w[k*4 +: 4] !== 4'(k)) chk("full_pattern", 32'(out_w[k*4 +: 4]), 32'(k % 16));
        end

        // Reset two transfers into a five-nibble burst, with a write offered alongside.
        done_seen = 0;
        drive(1'b1, 1'b1, 8'd100, 8'd5, 4'h0);
        tick();
        drive(1'b1, 1'b0, 8'd0, 8'd0, 4'h3);
        tick();
        tick();
        chk("mid_busy", 32'(busy_w), 32'd1);
        reset = 1'b1;
        drive(1'b1, 1'b0, 8'd1, 8'd0, 4'hE);
        tick();
        model_fill();
        chk_bank("mid_reset_bank");
        chk("mid_reset_busy", 32'(busy_w), 32'd0);
        chk("mid_reset_done", 32'(done_w), 32'd0);
        chk("mid_reset_rdy", 32'(wif.wr_ready), 32'd1);
        reset = 1'b0;
        drive(1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
        tick();
        chk("post_reset_busy", 32'(busy_w), 32'd0);
        chk("post_reset_pulses", 32'(done_seen), 32'd0);
        single_write(8'd3, 4'h9, "post_reset_sw");

`ifdef NIBBLE_READBACK_EN
        single_write(8'd7, 4'hC, "rb_wr");
        rd_sel = 8'd7;
        tick();
        chk("rb_7", 32'(rd_data), 32'hC);
        for (int i = 0; i < 10; i++) begin
            s = 8'($urandom);
            rd_sel = s;
            d = m[s];
            tick();
            chk("rb_rand", 32'(rd_data), 32'(d));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
